sample_deserializer: RTL
========================

Name: sample_deserializer

Overview:
- Serial-to-parallel front end of the FFT datapath.
- Accepts one complex_product_t sample per cycle on a valid/ready stream and assembles N consecutive samples into a frame.
- Presents each completed frame as an N-wide array, in arrival order, to the bit-reversal reorder stage directly downstream.
- Ping-pong (two-bank) buffering allows continuous one-sample-per-cycle input while the downstream stage holds a frame.

Parameters:
- N, 8, samples per frame. Must be a power of two and at least 2; any other value fails elaboration.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  write-side enable; when low, no input samples are accepted.
- in_sample  input  complex_product_t  incoming sample.
- in_valid  input  1  in_sample is valid.
- in_ready  output  1  block can accept in_sample this cycle.
- in_sof  input  1  start-of-frame marker qualifying in_sample (see Optional Feature).
- output_array  output  complex_product_t [N-1:0]  completed frame; element i is the i-th sample received.
- out_valid  output  1  output_array holds a complete frame.
- out_ready  input  1  downstream consumes the frame this cycle.
- frame_err  output  1  sticky frame-alignment error.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Storage:
  - Two banks, A and B, each N x complex_product_t.
  - State: wr_bank (1 bit), wr_idx ($clog2(N) bits), rd_bank (1 bit), bank_full[1:0].
- Reset (synchronous, active-high), effective the cycle after reset is sampled high:
  - wr_bank=0, rd_bank=0, wr_idx=0, bank_full=0.
  - Both banks cleared to 0; frame_err=0.
  - Outputs: out_valid=0, in_ready=0 while reset is high, output_array=all zeros.
  - Reset mid-frame discards all partial and full frames.
- Handshakes:
  - in_ready = enable & ~reset & ~bank_full[wr_bank]. Combinational from state only; no dependency on in_valid.
  - Accept = in_valid & in_ready.
- On accept:
  - bank[wr_bank][wr_idx] <= in_sample; wr_idx increments.
  - When wr_idx == N-1: set bank_full[wr_bank], toggle wr_bank, wr_idx wraps to 0.
- Output side:
  - out_valid = bank_full[rd_bank]; output_array = bank[rd_bank] (driven straight from registers).
  - Consume = out_valid & out_ready: clears bank_full[rd_bank] and toggles rd_bank.
- While out_valid=1 and out_ready=0: output_array and out_valid are held stable.
- enable=0 freezes the write side only (wr_idx and the partial frame are retained). The output side continues to drain normally.
- Latency: last sample of a frame accepted in cycle t -> out_valid=1 in cycle t+1.
- Throughput: N samples per N cycles, sustained indefinitely, with out_ready held high.
- Both banks full: in_ready=0 until one frame is consumed. in_ready returns high the cycle after the consume.
- A frame completion and a consume in the same cycle act on different banks. Both take effect.
- Bank contents are not cleared on consume; only the bank_full flag is cleared.

Optional Feature:
- Macro: DESER_SOF_ALIGN_EN.
- Defined:
  - An accepted sample with in_sof=1 is written to index 0 of the current write bank, and wr_idx becomes 1. Any partial frame is discarded.
  - If wr_idx != 0 at that accept, frame_err sets and stays high until reset.
  - in_sof=1 with wr_idx==0 is normal and raises no error.
- Undefined: in_sof is ignored and frame_err is constant 0.

Test Plan:
- Reset then stream: N=8, out_ready=1, stream samples re=1..16 on consecutive cycles -> out_valid pulses in the cycle after sample 8 and the cycle after sample 16. output_array[0..7] = 1..8, then 9..16. in_ready stays 1 throughout.
- Backpressure: out_ready=0, stream 24 samples -> two frames fill, in_ready drops to 0 after sample 16, samples 17+ are stalled. Raise out_ready for 1 cycle -> frame 1..8 consumed, frame 9..16 presented next, in_ready=1 on the following cycle.
- Enable gap: accept samples 1..3, hold enable=0 for 5 cycles with in_valid=1, then resume with 4..8 -> no samples accepted during the gap. Frame presented is 1..8 with no gaps.
- Reset mid-frame: accept 5 samples, pulse reset -> out_valid=0, output_array=0, next 8 accepted samples form the first frame.
- SOF realign (DESER_SOF_ALIGN_EN defined): accept 3 samples, then sample 100 with in_sof=1, then 101..107 -> frame = 100..107, frame_err=1 and sticky. Repeat after reset with in_sof only on the first sample -> frame_err stays 0.

Source files
------------

// File: rtl/sample_deserializer_if.sv
// Sample type shared by the FFT front end, plus the stream interface that carries
// serial samples into the deserializer and completed frames out of it.
package sample_deserializer_pkg;

   typedef struct packed {
      logic signed [15:0] re;
      logic signed [15:0] im;
   } complex_product_t;

endpackage

interface sample_deserializer_if #(
   parameter int N = 8
);
   import sample_deserializer_pkg::*;

   logic                        enable;
   complex_product_t            in_sample;
   logic                        in_valid;
   logic                        in_ready;
   logic                        in_sof;
   complex_product_t [N-1:0]    output_array;
   logic                        out_valid;
   logic                        out_ready;
   logic                        frame_err;

   // master is the producer/consumer around the block; slave is the deserializer itself
   modport master (
      output enable, in_sample, in_valid, in_sof, out_ready,
      input  in_ready, output_array, out_valid, frame_err
   );

   modport slave (
      input  enable, in_sample, in_valid, in_sof, out_ready,
      output in_ready, output_array, out_valid, frame_err
   );

endinterface

// File: rtl/sample_deserializer.sv
// Ping-pong serial-to-parallel deserializer: packs N consecutive samples into a frame.
// Optional start-of-frame realignment and sticky frame_err via `define DESER_SOF_ALIGN_EN.
module sample_deserializer
   import sample_deserializer_pkg::*;
#(
   parameter int N = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   sample_deserializer_if.slave  bus
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   generate
      if (N < 2 || (N & (N - 1)) != 0) begin : g_badN
         $error("sample_deserializer: N must be a power of two and at least 2");
      end
   endgenerate

   complex_product_t [N-1:0] r_bank [2];
   logic                     r_wrBank;
   logic                     r_rdBank;
   logic [IW-1:0]            r_wrIdx;
   logic [1:0]               r_bankFull;

   logic                     w_inReady;
   logic                     w_accept;
   logic                     w_outValid;
   logic                     w_consume;
   logic                     w_lastIdx;

   assign w_inReady  = bus.enable & ~reset & ~r_bankFull[r_wrBank];
   assign w_accept   = bus.in_valid & w_inReady;
   assign w_outValid = r_bankFull[r_rdBank];
   assign w_consume  = w_outValid & bus.out_ready;
   assign w_lastIdx  = (r_wrIdx == IW'(N - 1));

   assign bus.in_ready     = w_inReady;
   assign bus.out_valid    = w_outValid;
   assign bus.output_array = r_bank[r_rdBank];

`ifdef DESER_SOF_ALIGN_EN
   logic r_frameErr;
   assign bus.frame_err = r_frameErr;

   // A consume and a completion always touch different banks, so both updates apply.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_bank[0]  <= '0;
         r_bank[1]  <= '0;
         r_wrBank   <= 1'b0;
         r_rdBank   <= 1'b0;
         r_wrIdx    <= '0;
         r_bankFull <= '0;
         r_frameErr <= 1'b0;
      end else begin
         if (w_consume) begin
            r_bankFull[r_rdBank] <= 1'b0;
            r_rdBank             <= ~r_rdBank;
         end
         if (w_accept) begin
            if (bus.in_sof) begin
               r_bank[r_wrBank][0] <= bus.in_sample;
               r_wrIdx             <= IW'(1);
               if (r_wrIdx != '0) begin
                  r_frameErr <= 1'b1;
               end
            end else begin
               r_bank[r_wrBank][r_wrIdx] <= bus.in_sample;
               if (w_lastIdx) begin
                  r_bankFull[r_wrBank] <= 1'b1;
                  r_wrBank             <= ~r_wrBank;
                  r_wrIdx              <= '0;
               end else begin
                  r_wrIdx <= r_wrIdx + IW'(1);
               end
            end
         end
      end
   end
`else
   logic w_unusedSof;
   assign w_unusedSof   = bus.in_sof;
   assign bus.frame_err = 1'b0;

   // A consume and a completion always touch different banks, so both updates apply.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_bank[0]  <= '0;
         r_bank[1]  <= '0;
         r_wrBank   <= 1'b0;
         r_rdBank   <= 1'b0;
         r_wrIdx    <= '0;
         r_bankFull <= '0;
      end else begin
         if (w_consume) begin
            r_bankFull[r_rdBank] <= 1'b0;
            r_rdBank             <= ~r_rdBank;
         end
         if (w_accept) begin
            r_bank[r_wrBank][r_wrIdx] <= bus.in_sample;
            if (w_lastIdx) begin
               r_bankFull[r_wrBank] <= 1'b1;
               r_wrBank             <= ~r_wrBank;
               r_wrIdx              <= '0;
            end else begin
               r_wrIdx <= r_wrIdx + IW'(1);
            end
         end
      end
   end
`endif

endmodule
